// File: rtl/rs232_tap_rx.sv
// Passive 8N1 tap receiver: 16x oversampled decoder feeding a show-ahead FIFO of {ferr, data},
// with a sticky overflow flag and a stretched line-activity indicator.
module rs232_tap_rx #(
    parameter int OVERSAMPLE_DIV  = 27,
    parameter int FIFO_LOG2       = 4,
    parameter int ACTIVITY_CYCLES = 2500000
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_N,
    input  logic                 line_in,
    output logic [7:0]           byte_data,
    output logic                 byte_ferr,
    output logic                 byte_valid,
    input  logic                 byte_ready,
    output logic [FIFO_LOG2:0]   fifo_level,
    output logic                 overflow,
    input  logic                 clear_status,
    output logic                 line_active
);
    localparam int DW    = $clog2(OVERSAMPLE_DIV);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int LW    = FIFO_LOG2 + 1;
    localparam int AW    = $clog2(ACTIVITY_CYCLES + 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE} state_t;

    logic [1:0]           r_sync;
    logic                 w_rx;
    logic [DW-1:0]        r_div;
    logic                 w_tick;
    state_t               r_state, w_state_nx;
    logic [3:0]           r_tc, w_tc_nx;
    logic [2:0]           r_bi, w_bi_nx;
    logic [7:0]           r_shift, w_shift_nx;
    logic                 w_push, w_push_ferr;
    logic [8:0]           r_mem [DEPTH];
    logic [FIFO_LOG2-1:0] r_wp, r_rp;
    logic [LW-1:0]        r_level;
    logic                 r_ovf;
    logic                 w_full, w_pop, w_wr, w_drop;
    logic                 r_rx_d;
    logic [AW-1:0]        r_act;

    assign w_rx   = r_sync[1];
    assign w_tick = (r_div == DW'(OVERSAMPLE_DIV - 1));

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync <= 2'b11;
            r_div  <= '0;
        end else begin
            r_sync <= {r_sync[0], line_in};
            r_div  <= w_tick ? '0 : r_div + DW'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_tc    <= '0;
            r_bi    <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nx;
            r_tc    <= w_tc_nx;
            r_bi    <= w_bi_nx;
            r_shift <= w_shift_nx;
        end
    end

    always_comb begin
        w_state_nx  = r_state;
        w_tc_nx     = r_tc;
        w_bi_nx     = r_bi;
        w_shift_nx  = r_shift;
        w_push      = 1'b0;
        w_push_ferr = 1'b0;
        if (w_tick) begin
            case (r_state)
                S_IDLE: if (!w_rx) begin
                    w_state_nx = S_START;
                    w_tc_nx    = '0;
                end
                // The detecting tick is the first start-bit tick, so mid-start lands 7 ticks in.
                S_START: if (r_tc == 4'd6) begin
                    w_state_nx = w_rx ? S_IDLE : S_DATA;
                    w_tc_nx    = '0;
                    w_bi_nx    = '0;
                end else begin
                    w_tc_nx = r_tc + 4'd1;
                end
                S_DATA: if (r_tc == 4'd15) begin
                    w_shift_nx[r_bi] = w_rx;
                    w_tc_nx          = '0;
                    w_bi_nx          = r_bi + 3'd1;
                    if (r_bi == 3'd7) w_state_nx = S_STOP;
                end else begin
                    w_tc_nx = r_tc + 4'd1;
                end
                S_STOP: if (r_tc == 4'd15) begin
                    w_push      = 1'b1;
                    w_push_ferr = ~w_rx;
                    w_tc_nx     = '0;
                    w_state_nx  = w_rx ? S_IDLE : S_WAIT_IDLE;
                end else begin
                    w_tc_nx = r_tc + 4'd1;
                end
                S_WAIT_IDLE: if (w_rx) w_state_nx = S_IDLE;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    // A push into a full FIFO is still accepted when the head pops in the same cycle.
    assign w_full = (r_level == LW'(DEPTH));
    assign w_pop  = byte_valid & byte_ready;
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge CLOCK_50) begin
        if (w_wr) r_mem[r_wp] <= {w_push_ferr, r_shift};
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)  r_wp <= r_wp + FIFO_LOG2'(1);
            if (w_pop) r_rp <= r_rp + FIFO_LOG2'(1);
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_drop)            r_ovf <= 1'b1;
            else if (clear_status) r_ovf <= 1'b0;
        end
    end

    assign byte_valid              = (r_level != '0);
    assign {byte_ferr, byte_data}  = byte_valid ? r_mem[r_rp] : 9'd0;
    assign fifo_level              = r_level;
    assign overflow                = r_ovf;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_rx_d <= 1'b1;
            r_act  <= '0;
        end else begin
            r_rx_d <= w_rx;
            if (w_rx != r_rx_d)  r_act <= AW'(ACTIVITY_CYCLES - 1);
            else if (r_act != '0) r_act <= r_act - AW'(1);
        end
    end

    assign line_active = (r_act != '0);
endmodule

// File: tb/tb_rs232_tap_rx.sv
// Bench for rs232_tap_rx: frame-level stimulus, queue scoreboard on every pop, table vectors
// and hand-written corner sequences (glitch, break, overflow, full+pop, reset mid-frame).
module tb_rs232_tap_rx;
    localparam int DIV   = 5;
    localparam int L2    = 4;
    localparam int ACT   = 1000;
    localparam int BIT   = 16 * DIV;
    localparam int DEPTH = 1 << L2;

    logic          clk = 1'b0, rst_n = 1'b0, line_in = 1'b1, byte_ready = 1'b0, clear_status = 1'b0;
    logic [7:0]    byte_data;
    logic          byte_ferr, byte_valid, overflow, line_active;
    logic [L2:0]   fifo_level;

    always #5 clk = ~clk;

    rs232_tap_rx #(.OVERSAMPLE_DIV(DIV), .FIFO_LOG2(L2), .ACTIVITY_CYCLES(ACT)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .line_in(line_in),
        .byte_data(byte_data), .byte_ferr(byte_ferr), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .fifo_level(fifo_level), .overflow(overflow),
        .clear_status(clear_status), .line_active(line_active)
    );

    typedef struct {
        logic [7:0] data;
        bit         stop_hi;
        logic [7:0] exp_data;
        bit         exp_ferr;
    } vec_t;

    int         n_chk = 0, n_fail = 0, pop_cnt = 0;
    logic [8:0] exp_q[$];
    bit         model_ovf = 1'b0;
    bit         rnd_on;
    int         p0;
    vec_t       tbl[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted pop must match the oldest byte the model expects.
    initial forever begin
        @(negedge clk); #2;
        if (rst_n && byte_valid && byte_ready) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_pop: got %0h expected no entry", byte_data);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                check("pop_data", byte_data, e[7:0]);
                check("pop_ferr", byte_ferr, e[8]);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_push(input logic [7:0] d, input bit ferr, input bit pop_at_push);
        if (exp_q.size() < DEPTH || pop_at_push) exp_q.push_back({ferr, d});
        else model_ovf = 1'b1;
    endtask

    // One 8N1 frame; a low stop bit is followed by 3 more low bit periods, then idle.
    task automatic send_frame(input logic [7:0] d, input bit stop_hi, input bit pop_at_push);
        model_push(d, !stop_hi, pop_at_push);
        line_in = 1'b0; cyc(BIT);
        for (int i = 0; i < 8; i++) begin line_in = d[i]; cyc(BIT); end
        line_in = stop_hi; cyc(BIT);
        if (!stop_hi) begin cyc(3 * BIT); line_in = 1'b1; cyc(BIT); end
    endtask

    task automatic wait_level(input int lvl, input int maxc, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (fifo_level == lvl[L2:0]) begin ok = 1'b1; break; end
        end
        check(name, ok, 1);
    endtask

    task automatic expect_head(input string name, input logic [7:0] d, input bit f);
        bit ok = 1'b0;
        for (int i = 0; i < 2 * BIT; i++) begin
            @(negedge clk);
            if (byte_valid) begin ok = 1'b1; break; end
        end
        check({name, "_valid"}, ok, 1);
        check({name, "_data"}, byte_data, d);
        check({name, "_ferr"}, byte_ferr, f);
        check({name, "_level"}, fifo_level, 1);
        cyc(1);
        byte_ready = 1'b1; cyc(1); byte_ready = 1'b0;
    endtask

    initial begin
        tbl[0] = '{8'h00, 1'b1, 8'h00, 1'b0};
        tbl[1] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
        tbl[2] = '{8'h80, 1'b1, 8'h80, 1'b0};
        tbl[3] = '{8'h01, 1'b1, 8'h01, 1'b0};
        tbl[4] = '{8'h5A, 1'b0, 8'h5A, 1'b1};
        tbl[5] = '{8'h00, 1'b0, 8'h00, 1'b1};
        tbl[6] = '{8'hB6, 1'b1, 8'hB6, 1'b0};

        cyc(5);
        @(negedge clk);
        check("rst_valid", byte_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_active", line_active, 0);
        check("rst_data", byte_data, 0);
        check("rst_ferr", byte_ferr, 0);
        cyc(1); rst_n = 1'b1; cyc(BIT);

        // Decode latency with a ready consumer.
        byte_ready = 1'b1;
        p0 = pop_cnt;
        fork
            send_frame(8'h55, 1'b1, 1'b0);
            begin
                bit ok = 1'b0;
                for (int i = 0; i < 10 * BIT + 30; i++) begin
                    @(negedge clk); #3;
                    if (pop_cnt != p0) begin ok = 1'b1; break; end
                end
                check("t1_latency", ok, 1);
            end
        join
        byte_ready = 1'b0;
        cyc(BIT);

        // Short low pulse must not start a frame.
        p0 = pop_cnt;
        line_in = 1'b0; cyc(4 * DIV); line_in = 1'b1; cyc(2 * BIT);
        @(negedge clk);
        check("t2_level", fifo_level, 0);
        check("t2_valid", byte_valid, 0);
        check("t2_pops", pop_cnt, p0);
        cyc(1);
        send_frame(8'hA5, 1'b1, 1'b0);
        expect_head("t2_a5", 8'hA5, 1'b0);

        // Framing error followed by a clean byte.
        send_frame(8'h0F, 1'b0, 1'b0);
        expect_head("t3_ferr", 8'h0F, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b0);
        expect_head("t3_3c", 8'h3C, 1'b0);

        for (int k = 0; k < 7; k++) begin
            send_frame(tbl[k].data, tbl[k].stop_hi, 1'b0);
            expect_head($sformatf("tbl%0d", k), tbl[k].exp_data, tbl[k].exp_ferr);
        end

        // Overflow: 17 frames with no consumer.
        for (int k = 0; k < 17; k++) send_frame(k[7:0], 1'b1, 1'b0);
        cyc(BIT);
        @(negedge clk);
        check("t4_level", fifo_level, DEPTH);
        check("t4_ovf", overflow, model_ovf);
        cyc(1);
        byte_ready = 1'b1;
        wait_level(0, 4 * DEPTH, "t4_drain");
        byte_ready = 1'b0;
        check("t4_ovf_sticky", overflow, 1);
        check("t4_q_empty", exp_q.size(), 0);
        cyc(1);
        clear_status = 1'b1; cyc(1); clear_status = 1'b0;
        model_ovf = 1'b0;
        @(negedge clk);
        check("t4_ovf_clr", overflow, model_ovf);
        cyc(1);

        // Full FIFO with a pop on the exact push cycle.
        for (int k = 0; k < DEPTH; k++) send_frame(8'h20 + k[7:0], 1'b1, 1'b0);
        @(negedge clk);
        check("t5_full", fifo_level, DEPTH);
        cyc(1);
        fork
            send_frame(8'h30, 1'b1, 1'b1);
            begin
                bit ok = 1'b0;
                for (int i = 0; i < 11 * BIT; i++) begin
                    @(negedge clk);
                    if (dut.w_push) begin
                        #1 byte_ready = 1'b1;
                        @(posedge clk); #1 byte_ready = 1'b0;
                        ok = 1'b1;
                        break;
                    end
                end
                check("t5_push_seen", ok, 1);
                @(negedge clk);
                check("t5_level", fifo_level, DEPTH);
                check("t5_ovf", overflow, 0);
            end
        join
        byte_ready = 1'b1;
        wait_level(0, 4 * DEPTH, "t5_drain");
        byte_ready = 1'b0;
        check("t5_q_empty", exp_q.size(), 0);
        cyc(1);

        // Reset during data bit 3 with one byte already queued.
        send_frame(8'h99, 1'b1, 1'b0);
        line_in = 1'b0; cyc(BIT);
        for (int i = 0; i < 3; i++) begin line_in = 1'(8'hE7 >> i); cyc(BIT); end
        line_in = 1'b0; cyc(BIT / 2);
        rst_n = 1'b0;
        #2;
        check("t6_valid", byte_valid, 0);
        check("t6_level", fifo_level, 0);
        check("t6_active", line_active, 0);
        check("t6_ovf", overflow, 0);
        check("t6_data", byte_data, 0);
        exp_q.delete();
        line_in = 1'b1; cyc(3); rst_n = 1'b1; cyc(BIT);
        fork
            send_frame(8'hC3, 1'b1, 1'b0);
            begin
                repeat (4) @(negedge clk);
                check("t6_act_rise", line_active, 1);
                repeat (7 * BIT + ACT - 8) @(negedge clk);
                check("t6_act_hold", line_active, 1);
                repeat (10) @(negedge clk);
                check("t6_act_fall", line_active, 0);
            end
        join
        expect_head("t6_c3", 8'hC3, 1'b0);

        // Random bytes, random stop bits and a random consumer.
        rnd_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    logic [7:0] d;
                    d = 8'($urandom);
                    send_frame(d, ($urandom % 4) != 0, 1'b0);
                end
                rnd_on = 1'b0;
            end
            while (rnd_on) begin
                @(posedge clk); #1 byte_ready = 1'($urandom % 2);
            end
        join
        byte_ready = 1'b1;
        wait_level(0, 4 * DEPTH, "rnd_drain");
        byte_ready = 1'b0;
        cyc(2);
        check("rnd_q_empty", exp_q.size(), 0);
        check("rnd_ovf", overflow, model_ovf);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/rs232_tap_rx.md
# rs232_tap_rx

Passive 8N1 UART receiver that taps one RS232 passthrough wire (e.g. A_RXD or B_TXD on the Daisho RS232 front-end) downstream of the passthrough wiring. It decodes bytes without disturbing the line. It queues them with a per-byte framing-error flag in a small show-ahead FIFO for a sniffer/logger consumer, and provides a stretched activity indicator for LEDs.

## Interface
- OVERSAMPLE_DIV, 27: CLOCK_50 cycles per 16x oversample tick (27 gives 115200 baud at 50 MHz); must be ≥ 2.
- FIFO_LOG2, 4: FIFO depth = 2^FIFO_LOG2 entries of 9 bits {ferr, data}.
- ACTIVITY_CYCLES, 2500000: line_active stretch length in clocks (50 ms).

Ports:
- CLOCK_50  in  1  system clock; everything is on its rising edge.
- RESET_N  in  1  reset; asynchronous, active-low.
- line_in  in  1  raw tapped RS232 line, idle high, asynchronous to CLOCK_50.
- byte_data  out  8  FIFO head data (LSB = first received bit).
- byte_ferr  out  1  FIFO head framing-error flag (stop bit sampled low).
- byte_valid  out  1  FIFO non-empty.
- byte_ready  in  1  consumer accepts head when byte_valid & byte_ready.
- fifo_level  out  FIFO_LOG2+1  number of queued entries, 0..2^FIFO_LOG2.
- overflow  out  1  sticky; a decoded byte was dropped because the FIFO was full.
- clear_status  in  1  synchronous one-cycle clear of overflow.
- line_active  out  1  high for ACTIVITY_CYCLES after any edge on the synchronized line.

## Operation
- Synchronizer: 2 flops, both reset to 1. All logic uses the synchronized value `rx`.
- Tick generator: free-running counter 0..OVERSAMPLE_DIV-1 that never resynchronizes. `tick` is high for one clock when the count equals OVERSAMPLE_DIV-1.
- FSM (advances only on tick cycles unless stated), with a 4-bit tick counter `tc` and a 3-bit bit index `bi`:
  - IDLE: on a tick with rx=0, go to START with tc=0.
  - START: tc increments each tick. At tc=7, mid start bit: if rx=0, go to DATA with tc=0 and bi=0; if rx=1, it was a glitch, so return to IDLE and push nothing.
  - DATA: at tc=15, sample rx into shift[bi] (LSB first), set tc=0, bi+1. After bi=7 is sampled, go to STOP.
  - STOP: at tc=15, push {~rx, shift}. If rx=1, go to IDLE. If rx=0 (framing error or break), go to WAIT_IDLE.
  - WAIT_IDLE: stay until a tick with rx=1, then go to IDLE. A held break produces exactly one entry.
- FIFO: circular RAM with read/write pointers, show-ahead, so byte_data and byte_ferr reflect the head combinationally from registered state.
  - Pop = byte_valid & byte_ready.
  - A push while full with no pop drops the byte and sets overflow.
  - Push and pop in the same cycle when full: both are accepted and the level stays the same.
  - Push and pop in the same cycle at any other level: level is unchanged.
  - Pointers wrap modulo 2^FIFO_LOG2. fifo_level never exceeds 2^FIFO_LOG2 and never underflows.
- overflow: cleared by clear_status. If a drop and clear_status occur in the same cycle, the set wins.
- line_active: a down-counter reloads ACTIVITY_CYCLES-1 on any rx change, otherwise decrements toward 0. line_active = (counter ≠ 0).

## Timing
- Reset values: byte_valid=0, fifo_level=0, overflow=0, line_active=0, byte_data=0, byte_ferr=0, FSM=IDLE, both pointers=0. byte_data and byte_ferr are don't-care whenever byte_valid=0 after reset.
- Reset mid-frame discards the partial byte; the next decode starts from IDLE.
- Start detection latency: 2 clocks (synchronizer) plus up to one tick period (OVERSAMPLE_DIV clocks).
- Stop-bit sample is 7+16×9 = 151 ticks after the detecting tick. byte_valid rises the clock after the push, when the FIFO was empty.
- Sampling points sit at 7/16 into each bit, ±1 tick. Tolerance is about ±3% baud mismatch.
- fifo_level, overflow and byte_valid update the clock after the push/pop event.
- Back-to-back frames with no idle gap are supported: the next start bit may begin immediately after the stop sample, and IDLE detects it on the next tick.

## Test plan
1. Send 0x55, 8N1, bit period 432 clocks (DIV=27), byte_ready=1 -> one pop with byte_data=0x55, byte_ferr=0, within 10 bit periods + 30 clocks of the start edge.
2. Glitch: line low for 108 clocks (4 ticks) then high -> no push, FSM back in IDLE, fifo_level=0; a subsequent 0xA5 frame decodes correctly.
3. Framing error: send 0x0F with stop bit low, hold the line low 3 bit periods, then high -> exactly one entry {ferr=1, 0x0F}; the following 0x3C decodes with ferr=0.
4. Overflow: byte_ready=0, send 17 frames 0x00..0x10 -> fifo_level=16, overflow=1. Draining yields 0x00..0x0F in order and fifo_level=0. clear_status then sets overflow=0.
5. Full plus simultaneous pop: FIFO full, byte_ready pulsed on the exact push cycle -> the new byte is accepted, fifo_level stays 16, overflow stays 0.
6. Reset mid-frame: RESET_N low during data bit 3 -> all outputs take their reset values immediately. After release, hold the line high one bit period, then send 0xC3 -> decoded 0xC3, ferr=0; line_active high within 3 clocks of the first edge, low ACTIVITY_CYCLES after the last edge.
